// File: rtl/cache_pkg.sv
// Shared definitions for the parametrised data cache: controller states
// and the field-width helpers used to split a byte address into
// tag / index / word offset / byte offset.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WB,
      LD,
      FSCAN,
      FWB,
      STAT1,
      STAT2,
      HALT
   } dcache_state_t;

   localparam int WORD_W     = 32;
   localparam int BYTE_OFF_W = 2;

   function automatic int off_w(input int words);
      return $clog2(words);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   // A direct-mapped cache still needs a 1-bit way select to index its arrays.
   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic int tag_w(input int sets, input int words);
      return WORD_W - BYTE_OFF_W - off_w(words) - idx_w(sets);
   endfunction

endpackage

// File: rtl/lru_ages.sv
// True-LRU age tracker, one age vector per set.
// Ports: CLK/nRST clock and async active-low reset; touch marks way `way`
// of set `set` as most recently used; victim is the oldest way of `set`.
module lru_ages
   import cache_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 8,
   localparam int WAY_W = way_w(WAYS),
   localparam int IDX_W = idx_w(SETS)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             touch,
   input  logic [IDX_W-1:0] set,
   input  logic [WAY_W-1:0] way,
   output logic [WAY_W-1:0] victim
);

   logic [WAY_W-1:0] age [SETS][WAYS];
   logic [WAY_W-1:0] old_age;

   assign old_age = age[set][way];

   // Touched way becomes 0; every way younger than it ages by one, so the
   // ages of a set stay a permutation of 0..WAYS-1.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age[s][w] <= WAY_W'(w);
      end else if (touch) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == way)
               age[set][w] <= '0;
            else if (age[set][w] < old_age)
               age[set][w] <= age[set][w] + WAY_W'(1);
         end
      end
   end

   always_comb begin
      victim = '0;
      for (int w = 0; w < WAYS; w++)
         if (age[set][w] == WAY_W'(WAYS - 1))
            victim = WAY_W'(w);
   end

endmodule

// File: rtl/dcache_param.sv
// Parametrised write-back, write-allocate, N-way set-associative data cache.
// Datapath side: halt, dmemREN/dmemWEN/dmemaddr/dmemstore in; dhit,
// dmemload, flushed out. Memory side: dREN/dWEN/daddr/dstore out; dload,
// dwait in (a transfer completes in the cycle dwait is low).
// On halt, every dirty block is written back, then the hit and miss
// counters are stored at STAT_ADDR and STAT_ADDR+4 and flushed is raised.
module dcache_param
   import cache_pkg::*;
#(
   parameter int          SETS      = 8,
   parameter int          WAYS      = 2,
   parameter int          WORDS     = 2,
   parameter logic [31:0] STAT_ADDR = 32'h3100
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        halt,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic [31:0] dload,
   input  logic        dwait
);

   localparam int OFF_W = off_w(WORDS);
   localparam int IDX_W = idx_w(SETS);
   localparam int WAY_W = way_w(WAYS);
   localparam int TAG_W = tag_w(SETS, WORDS);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
      logic [OFF_W-1:0] word;
      logic [1:0]       byte_off;
   } addr_t;

   addr_t            req;
   logic [1:0]       unused_byte_off;

   dcache_state_t    state, state_n;
   logic [31:0]      data [SETS][WAYS][WORDS];
   logic [TAG_W-1:0] tags [SETS][WAYS];
   logic [WAYS-1:0]  valid [SETS];
   logic [WAYS-1:0]  dirty [SETS];

   logic [WAY_W-1:0] vic_way, fway;
   logic [IDX_W-1:0] vic_idx, fset;
   logic [TAG_W-1:0] miss_tag;
   logic [OFF_W-1:0] wcnt;
   logic [31:0]      hit_count, miss_count;
   logic             fill_done;

   logic             req_valid, hit_any, inv_any, idle_hit, victim_dirty;
   logic             word_last, entry_last, entry_dirty;
   logic [WAY_W-1:0] hit_way, inv_way, lru_victim, victim;

   assign req             = dmemaddr;
   assign unused_byte_off = req.byte_off;
   assign req_valid       = dmemREN | dmemWEN;
   assign word_last       = (wcnt == OFF_W'(WORDS - 1));
   assign entry_last      = (fset == IDX_W'(SETS - 1)) && (fway == WAY_W'(WAYS - 1));
   assign entry_dirty     = valid[fset][fway] && dirty[fset][fway];

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block leaves a value unassigned (no latch inferred).
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      // Descending scan so the lowest-index invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[req.idx][w] && (tags[req.idx][w] == req.tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid[req.idx][w]) begin
            inv_any = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
   end

   assign idle_hit     = (state == IDLE) && !halt && req_valid && hit_any;
   assign victim       = inv_any ? inv_way : lru_victim;
   assign victim_dirty = valid[req.idx][victim] && dirty[req.idx][victim];

   lru_ages #(.WAYS(WAYS), .SETS(SETS)) u_lru (
      .CLK    (CLK),
      .nRST   (nRST),
      .touch  (idle_hit),
      .set    (req.idx),
      .way    (hit_way),
      .victim (lru_victim)
   );

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample pre-edge values regardless of evaluation order.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      dhit     = idle_hit;
      dmemload = idle_hit ? data[req.idx][hit_way][req.word] : '0;
      flushed  = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      daddr    = '0;
      dstore   = '0;
      case (state)
         IDLE: begin
            if (halt)                      state_n = FSCAN;
            else if (req_valid && !hit_any) state_n = victim_dirty ? WB : LD;
         end
         WB: begin
            dWEN   = 1'b1;
            daddr  = {tags[vic_idx][vic_way], vic_idx, wcnt, 2'b00};
            dstore = data[vic_idx][vic_way][wcnt];
            if (!dwait && word_last) state_n = LD;
         end
         LD: begin
            dREN  = 1'b1;
            daddr = {miss_tag, vic_idx, wcnt, 2'b00};
            if (!dwait && word_last) state_n = IDLE;
         end
         FSCAN: begin
            if (entry_dirty)     state_n = FWB;
            else if (entry_last) state_n = STAT1;
         end
         FWB: begin
            dWEN   = 1'b1;
            daddr  = {tags[fset][fway], fset, wcnt, 2'b00};
            dstore = data[fset][fway][wcnt];
            if (!dwait && word_last) state_n = entry_last ? STAT1 : FSCAN;
         end
         STAT1: begin
            dWEN   = 1'b1;
            daddr  = STAT_ADDR;
            dstore = hit_count;
            if (!dwait) state_n = STAT2;
         end
         STAT2: begin
            dWEN   = 1'b1;
            daddr  = STAT_ADDR + 32'd4;
            dstore = miss_count;
            if (!dwait) state_n = HALT;
         end
         HALT:    flushed = 1'b1;
         default: state_n = IDLE;
      endcase
   end

   // Bookkeeping: valid/dirty bits, miss context, counters, flush cursor.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            dirty[s] <= '0;
         end
         vic_way    <= '0;
         vic_idx    <= '0;
         miss_tag   <= '0;
         wcnt       <= '0;
         fset       <= '0;
         fway       <= '0;
         hit_count  <= '0;
         miss_count <= '0;
         fill_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Only the re-request right after a fill is excused from the count.
               fill_done <= 1'b0;
               if (halt) begin
                  fset <= '0;
                  fway <= '0;
                  wcnt <= '0;
               end else if (req_valid) begin
                  if (hit_any) begin
                     if (!fill_done) hit_count <= hit_count + 32'd1;
                     if (dmemWEN)    dirty[req.idx][hit_way] <= 1'b1;
                  end else begin
                     vic_way    <= victim;
                     vic_idx    <= req.idx;
                     miss_tag   <= req.tag;
                     wcnt       <= '0;
                     miss_count <= miss_count + 32'd1;
                  end
               end
            end
            WB: if (!dwait) wcnt <= wcnt + OFF_W'(1);
            LD: if (!dwait) begin
               wcnt <= wcnt + OFF_W'(1);
               if (word_last) begin
                  valid[vic_idx][vic_way] <= 1'b1;
                  dirty[vic_idx][vic_way] <= 1'b0;
                  fill_done               <= 1'b1;
               end
            end
            FSCAN: if (!entry_dirty) begin
               valid[fset][fway] <= 1'b0;
               if (fway == WAY_W'(WAYS - 1)) begin
                  fway <= '0;
                  fset <= fset + IDX_W'(1);
               end else fway <= fway + WAY_W'(1);
            end
            FWB: if (!dwait) begin
               wcnt <= wcnt + OFF_W'(1);
               if (word_last) begin
                  valid[fset][fway] <= 1'b0;
                  dirty[fset][fway] <= 1'b0;
                  if (fway == WAY_W'(WAYS - 1)) begin
                     fway <= '0;
                     fset <= fset + IDX_W'(1);
                  end else fway <= fway + WAY_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the data and tag arrays have no reset; the cleared valid bits
   // already make every stale entry unreachable.
   always_ff @(posedge CLK) begin
      if (idle_hit && dmemWEN)
         data[req.idx][hit_way][req.word] <= dmemstore;
      if (state == LD && !dwait) begin
         data[vic_idx][vic_way][wcnt] <= dload;
         if (word_last) tags[vic_idx][vic_way] <= miss_tag;
      end
   end

endmodule

// File: tb/tb_dcache_param.sv
// Directed bench for dcache_param: a default instance (8 sets, 2 ways,
// 2 words) and a 4-way instance share one memory model, selected by `sel`.
// The memory returns {16'hA5A5, daddr[15:0]} on reads and holds dwait high
// for `lat` cycles per transfer; every completed transfer is logged.
module tb_dcache_param;

   logic        CLK = 1'b0;
   logic        nRST, halt, ren, wen, sel;
   logic [31:0] addr, store;
   int          lat;

   logic        dhit0, flushed0, dren0, dwen0, dhit1, flushed1, dren1, dwen1;
   logic [31:0] dmemload0, daddr0, dstore0, dmemload1, daddr1, dstore1;
   logic        m_dhit, m_flushed, m_dren, m_dwen, dwait;
   logic [31:0] m_dmemload, m_daddr, m_dstore, dload;

   int          wait_cnt;
   int          log_n = 0;
   int          n_hits = 0;
   logic        log_we   [64];
   logic [31:0] log_addr [64];
   logic [31:0] log_data [64];

   int          n_cmp = 0;
   int          n_err = 0;

   always #5 CLK = ~CLK;

   dcache_param dut0 (
      .CLK(CLK), .nRST(nRST), .halt(halt & ~sel),
      .dmemREN(ren & ~sel), .dmemWEN(wen & ~sel),
      .dmemaddr(addr), .dmemstore(store),
      .dhit(dhit0), .dmemload(dmemload0), .flushed(flushed0),
      .dREN(dren0), .dWEN(dwen0), .daddr(daddr0), .dstore(dstore0),
      .dload(dload), .dwait(dwait)
   );

   dcache_param #(.WAYS(4)) dut1 (
      .CLK(CLK), .nRST(nRST), .halt(halt & sel),
      .dmemREN(ren & sel), .dmemWEN(wen & sel),
      .dmemaddr(addr), .dmemstore(store),
      .dhit(dhit1), .dmemload(dmemload1), .flushed(flushed1),
      .dREN(dren1), .dWEN(dwen1), .daddr(daddr1), .dstore(dstore1),
      .dload(dload), .dwait(dwait)
   );

   assign m_dhit     = sel ? dhit1     : dhit0;
   assign m_dmemload = sel ? dmemload1 : dmemload0;
   assign m_flushed  = sel ? flushed1  : flushed0;
   assign m_dren     = sel ? dren1     : dren0;
   assign m_dwen     = sel ? dwen1     : dwen0;
   assign m_daddr    = sel ? daddr1    : daddr0;
   assign m_dstore   = sel ? dstore1   : dstore0;

   assign dload = {16'hA5A5, m_daddr[15:0]};
   assign dwait = (m_dren | m_dwen) && (wait_cnt < lat);

   always @(posedge CLK or negedge nRST) begin
      if (!nRST)                          wait_cnt <= 0;
      else if ((m_dren || m_dwen) && dwait) wait_cnt <= wait_cnt + 1;
      else                                wait_cnt <= 0;
   end

   always @(posedge CLK) begin
      if ((m_dren || m_dwen) && !dwait && log_n < 64) begin
         log_we[log_n]   <= m_dwen;
         log_addr[log_n] <= m_daddr;
         log_data[log_n] <= m_dwen ? m_dstore : dload;
         log_n           <= log_n + 1;
      end
      if (m_dhit) n_hits <= n_hits + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag, input int i, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
      check({tag, " op"},   log_we[i],   we);
      check({tag, " addr"}, log_addr[i], a);
      check({tag, " data"}, log_data[i], d);
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that consumed the hit.
   task automatic access(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output int cyc);
      ren   = !w;
      wen   = w;
      addr  = a;
      store = d;
      cyc   = 0;
      #1;
      while (!m_dhit && cyc < 200) begin
         @(posedge CLK); #1;
         cyc++;
      end
      check({tag, " dhit"}, m_dhit, 1'b1);
      rd = m_dmemload;
      @(posedge CLK); #1;
      ren = 1'b0;
      wen = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          cyc, base, hbase, k;

      nRST = 1'b0; halt = 1'b0; ren = 1'b0; wen = 1'b0; sel = 1'b0;
      addr = '0; store = '0; lat = 0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset dhit",     dhit0,     1'b0);
      check("reset dmemload", dmemload0, 32'h0);
      check("reset flushed",  flushed0,  1'b0);
      check("reset dREN",     dren0,     1'b0);
      check("reset dWEN",     dwen0,     1'b0);
      check("reset daddr",    daddr0,    32'h0);
      check("reset dstore",   dstore0,   32'h0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(posedge CLK); #1;

      // Read miss: two-word fill, then the re-request hits (not counted).
      base = log_n; hbase = n_hits;
      access("rd100", 1'b0, 32'h100, 32'h0, rd, cyc);
      check("rd100 data",    rd, 32'hA5A50100);
      check("rd100 latency", cyc, 3);
      check("rd100 xfers",   log_n - base, 2);
      check("rd100 dhits",   n_hits - hbase, 1);
      check_log("rd100 w0", base,     1'b0, 32'h100, 32'hA5A50100);
      check_log("rd100 w1", base + 1, 1'b0, 32'h104, 32'hA5A50104);

      // Write hit then read hit: no memory traffic (hits counted: 1, 2).
      base = log_n;
      access("wr100", 1'b1, 32'h100, 32'hDEADBEEF, rd, cyc);
      check("wr100 latency", cyc, 0);
      access("rd100b", 1'b0, 32'h100, 32'h0, rd, cyc);
      check("rd100b data",    rd, 32'hDEADBEEF);
      check("rd100b latency", cyc, 0);
      check("hits no xfers",  log_n - base, 0);

      // 0x140 fills way 1; 0x180 evicts dirty way 0 (LRU) with write-back.
      access("rd140", 1'b0, 32'h140, 32'h0, rd, cyc);
      check("rd140 data", rd, 32'hA5A50140);
      base = log_n;
      access("rd180", 1'b0, 32'h180, 32'h0, rd, cyc);
      check("rd180 data",  rd, 32'hA5A50180);
      check("rd180 xfers", log_n - base, 4);
      check_log("evict wb0", base,     1'b1, 32'h100, 32'hDEADBEEF);
      check_log("evict wb1", base + 1, 1'b1, 32'h104, 32'hA5A50104);
      check_log("evict ld0", base + 2, 1'b0, 32'h180, 32'hA5A50180);
      check_log("evict ld1", base + 3, 1'b0, 32'h184, 32'hA5A50184);

      // Dirty 0x140 (hit 3) and 0x108 in set 1 (miss 4, post-fill hit uncounted).
      access("wr140", 1'b1, 32'h140, 32'hCAFE0140, rd, cyc);
      check("wr140 latency", cyc, 0);
      access("wr108", 1'b1, 32'h108, 32'h12345678, rd, cyc);

      // halt with a hitting read in the same cycle: no dhit, flush begins.
      lat  = 3;
      base = log_n;
      halt = 1'b1; ren = 1'b1; addr = 32'h180;
      #1;
      check("halt beats req", m_dhit, 1'b0);
      @(posedge CLK); #1;
      ren = 1'b0;
      k = 0;
      while (!m_flushed && k < 500) begin
         @(posedge CLK); #1;
         k++;
      end
      check("flushed",      m_flushed, 1'b1);
      check("flush xfers",  log_n - base, 6);
      check_log("flush 140", base,     1'b1, 32'h140,  32'hCAFE0140);
      check_log("flush 144", base + 1, 1'b1, 32'h144,  32'hA5A50144);
      check_log("flush 108", base + 2, 1'b1, 32'h108,  32'h12345678);
      check_log("flush 10c", base + 3, 1'b1, 32'h10C,  32'hA5A5010C);
      check_log("stat hits", base + 4, 1'b1, 32'h3100, 32'd3);
      check_log("stat miss", base + 5, 1'b1, 32'h3104, 32'd4);
      ren = 1'b1; addr = 32'h180;
      repeat (3) @(posedge CLK);
      #1;
      check("halt no dhit",    m_dhit,    1'b0);
      check("halt no dREN",    m_dren,    1'b0);
      check("halt no dWEN",    m_dwen,    1'b0);
      check("halt flushed",    m_flushed, 1'b1);
      check("halt no xfers",   log_n - base, 6);
      ren = 1'b0; halt = 1'b0;

      // 4-way LRU: fill set 0 dirty, re-touch the first three, then miss.
      sel = 1'b1; lat = 1;
      @(posedge CLK); #1;
      for (int t = 0; t < 4; t++)
         access("lru fill", 1'b1, 32'h100 + 32'(t) * 32'h40, 32'hA0 + 32'(t), rd, cyc);
      for (int t = 0; t < 3; t++) begin
         access("lru touch", 1'b0, 32'h100 + 32'(t) * 32'h40, 32'h0, rd, cyc);
         check("lru touch data",    rd,  32'hA0 + 32'(t));
         check("lru touch latency", cyc, 0);
      end
      base = log_n;
      access("lru miss", 1'b0, 32'h200, 32'h0, rd, cyc);
      check("lru miss data", rd, 32'hA5A50200);
      check_log("lru wb0", base,     1'b1, 32'h1C0, 32'hA3);
      check_log("lru wb1", base + 1, 1'b1, 32'h1C4, 32'hA5A501C4);
      check_log("lru ld0", base + 2, 1'b0, 32'h200, 32'hA5A50200);

      // Reset in the middle of a write-back.
      sel = 1'b0; lat = 3;
      nRST = 1'b0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(posedge CLK); #1;
      access("rst wr100", 1'b1, 32'h100, 32'h11, rd, cyc);
      access("rst wr140", 1'b1, 32'h140, 32'h22, rd, cyc);
      ren = 1'b1; addr = 32'h180;
      k = 0;
      #1;
      while (!m_dwen && k < 50) begin
         @(posedge CLK); #1;
         k++;
      end
      check("wb started", m_dwen,   1'b1);
      check("wb addr",    m_daddr,  32'h100);
      check("wb data",    m_dstore, 32'h11);
      #2;
      nRST = 1'b0;
      #1;
      check("rst drops dWEN",  m_dwen,   1'b0);
      check("rst drops daddr", m_daddr,  32'h0);
      ren = 1'b0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(posedge CLK); #1;
      base = log_n;
      access("rst rd100", 1'b0, 32'h100, 32'h0, rd, cyc);
      check("rst rd100 missed", (cyc > 0), 1'b1);
      check("rst rd100 data",   rd, 32'hA5A50100);
      check_log("rst rd100 ld0", base, 1'b0, 32'h100, 32'hA5A50100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
